hazard_stall_ctrl: RTL and testbench

//  Stall-side partner of the EX-stage forwarding unit. Forwarding removes RAW hazards by

---
 rtl/hazard_stall_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall controller beside the ID stage: inserts load-use bubbles and freezes the
// pipeline while the data cache is busy, flagging a sticky error on a stuck miss.
module hazard_stall_ctrl #(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS1_i,
    input  logic [4:0]       IF_ID_RS2_i,
    input  logic             IF_ID_UsesRS2_i,
    input  logic [4:0]       ID_EX_RD_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             dcache_stall_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Stall_o,
    output logic             ID_EX_Bubble_o,
    output logic             Freeze_o,
    output logic             Error_o,
    output logic [CNT_W-1:0] Stall_cnt_o,
    output logic [CNT_W-1:0] LU_cnt_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(MISS_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
    logic              lu;
    logic              freeze;
    logic              bubble;

    assign lu = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
                ((ID_EX_RD_i == IF_ID_RS1_i) ||
                 (IF_ID_UsesRS2_i && (ID_EX_RD_i == IF_ID_RS2_i)));

    // wait_q counts consecutive busy cycles of the current miss, including the first one.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        error_d = error_q;
        freeze  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dcache_stall_i) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dcache_stall_i) begin
                    freeze = 1'b1;
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(MISS_TIMEOUT)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            end
            ERR: begin
                freeze  = 1'b1;
                error_d = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
        // A frozen pipeline never takes a NOP; load-use only acts on a live cycle.
        bubble = lu && !freeze;
        stall_cnt_d = stall_cnt_q;
        if (freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        lu_cnt_d = lu_cnt_q;
        if (bubble && (lu_cnt_q != {CNT_W{1'b1}})) begin
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wait_q      <= '0;
            error_q     <= 1'b0;
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            error_q     <= error_d;
            stall_cnt_q <= stall_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign Freeze_o       = freeze;
    assign ID_EX_Bubble_o = bubble;
    assign IF_ID_Stall_o  = freeze || lu;
    assign PCWrite_o      = !(freeze || lu);
    assign Error_o        = error_q;
    assign Stall_cnt_o    = stall_cnt_q;
    assign LU_cnt_o       = lu_cnt_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: load-use vector table, directed miss/timeout/reset
// sequences, and a randomized run against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  rs1, rs2, rd;
    logic        uses2, memread, dstall;

    logic        pcw, ifid, bub, frz, err;
    logic [31:0] scnt, lcnt;
    logic [1:0]  dbg;

    logic        s_pcw, s_ifid, s_bub, s_frz, s_err;
    logic [2:0]  s_scnt, s_lcnt;
    logic [1:0]  s_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IF_ID_RS1_i(rs1), .IF_ID_RS2_i(rs2), .IF_ID_UsesRS2_i(uses2),
        .ID_EX_RD_i(rd), .ID_EX_MemRead_i(memread), .dcache_stall_i(dstall),
        .PCWrite_o(pcw), .IF_ID_Stall_o(ifid), .ID_EX_Bubble_o(bub),
        .Freeze_o(frz), .Error_o(err), .Stall_cnt_o(scnt), .LU_cnt_o(lcnt),
        .dbg_state_o(dbg)
    );

    hazard_stall_ctrl #(.CNT_W(3), .MISS_TIMEOUT(8)) u_small (
        .clk_i(clk_i), .rst_i(rst_i),
        .IF_ID_RS1_i(rs1), .IF_ID_RS2_i(rs2), .IF_ID_UsesRS2_i(uses2),
        .ID_EX_RD_i(rd), .ID_EX_MemRead_i(memread), .dcache_stall_i(dstall),
        .PCWrite_o(s_pcw), .IF_ID_Stall_o(s_ifid), .ID_EX_Bubble_o(s_bub),
        .Freeze_o(s_frz), .Error_o(s_err), .Stall_cnt_o(s_scnt), .LU_cnt_o(s_lcnt),
        .dbg_state_o(s_dbg)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses2;
        logic [4:0] rd;
        logic       memread;
        logic       exp_lu;
    } lu_vec_t;

    lu_vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; uses2 = 1'b0; rd = 5'd0; memread = 1'b0; dstall = 1'b0;
    endtask

    task automatic set_lu_hazard();
        rs1 = 5'd5; rs2 = 5'd7; uses2 = 1'b1; rd = 5'd5; memread = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    int exp_lu_total;
    int m_run;
    bit m_err;
    longint m_scnt, m_lcnt;
    bit m_lu, m_frz;

    initial begin
        idle();
        vecs[0] = '{rs1: 5'd5,  rs2: 5'd7, uses2: 1'b1, rd: 5'd5,  memread: 1'b1, exp_lu: 1'b1};
        vecs[1] = '{rs1: 5'd0,  rs2: 5'd1, uses2: 1'b0, rd: 5'd0,  memread: 1'b1, exp_lu: 1'b0};
        vecs[2] = '{rs1: 5'd3,  rs2: 5'd9, uses2: 1'b0, rd: 5'd9,  memread: 1'b1, exp_lu: 1'b0};
        vecs[3] = '{rs1: 5'd3,  rs2: 5'd9, uses2: 1'b1, rd: 5'd9,  memread: 1'b1, exp_lu: 1'b1};
        vecs[4] = '{rs1: 5'd5,  rs2: 5'd5, uses2: 1'b1, rd: 5'd5,  memread: 1'b0, exp_lu: 1'b0};
        vecs[5] = '{rs1: 5'd31, rs2: 5'd2, uses2: 1'b1, rd: 5'd31, memread: 1'b1, exp_lu: 1'b1};
        vecs[6] = '{rs1: 5'd4,  rs2: 5'd6, uses2: 1'b1, rd: 5'd8,  memread: 1'b1, exp_lu: 1'b0};
        vecs[7] = '{rs1: 5'd0,  rs2: 5'd0, uses2: 1'b1, rd: 5'd0,  memread: 1'b1, exp_lu: 1'b0};

        // Reset values with idle inputs
        do_reset();
        #1;
        chk("rst_pcwrite", 32'(pcw), 32'd1);
        chk("rst_ifid",    32'(ifid), 32'd0);
        chk("rst_bubble",  32'(bub), 32'd0);
        chk("rst_freeze",  32'(frz), 32'd0);
        chk("rst_error",   32'(err), 32'd0);
        chk("rst_scnt",    scnt, 32'd0);
        chk("rst_lcnt",    lcnt, 32'd0);
        chk("rst_state",   32'(dbg), 32'd0);

        // Load-use detection table
        exp_lu_total = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; uses2 = vecs[i].uses2;
            rd = vecs[i].rd; memread = vecs[i].memread; dstall = 1'b0;
            #1;
            chk($sformatf("vec%0d_bubble", i), 32'(bub), 32'(vecs[i].exp_lu));
            chk($sformatf("vec%0d_ifid", i),   32'(ifid), 32'(vecs[i].exp_lu));
            chk($sformatf("vec%0d_pcw", i),    32'(pcw), 32'(!vecs[i].exp_lu));
            chk($sformatf("vec%0d_freeze", i), 32'(frz), 32'd0);
            if (vecs[i].exp_lu) exp_lu_total++;
        end
        @(negedge clk_i);
        idle();
        #1;
        chk("table_lcnt", lcnt, 32'(exp_lu_total));

        // Ten-cycle miss, then release
        do_reset();
        for (int i = 0; i < 10; i++) begin
            dstall = 1'b1;
            #1;
            chk($sformatf("miss_freeze%0d", i), 32'(frz), 32'd1);
            chk($sformatf("miss_pcw%0d", i),    32'(pcw), 32'd0);
            @(negedge clk_i);
        end
        dstall = 1'b0;
        #1;
        chk("release_freeze", 32'(frz), 32'd0);
        chk("release_pcw",    32'(pcw), 32'd1);
        chk("release_scnt",   scnt, 32'd10);
        @(negedge clk_i);
        chk("after_release_state", 32'(dbg), 32'd0);
        chk("after_release_scnt",  scnt, 32'd10);

        // Miss and load-use together; bubble only on the release cycle
        do_reset();
        set_lu_hazard();
        dstall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mlu_freeze%0d", i), 32'(frz), 32'd1);
            chk($sformatf("mlu_bubble%0d", i), 32'(bub), 32'd0);
            chk($sformatf("mlu_ifid%0d", i),   32'(ifid), 32'd1);
            @(negedge clk_i);
        end
        dstall = 1'b0;
        #1;
        chk("mlu_rel_bubble", 32'(bub), 32'd1);
        chk("mlu_rel_freeze", 32'(frz), 32'd0);
        chk("mlu_rel_pcw",    32'(pcw), 32'd0);
        chk("mlu_rel_lcnt",   lcnt, 32'd0);
        @(negedge clk_i);
        idle();
        #1;
        chk("mlu_lcnt", lcnt, 32'd1);
        chk("mlu_scnt", scnt, 32'd3);

        // Timeout on the small instance (MISS_TIMEOUT=8, 3-bit counters)
        do_reset();
        dstall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("to_err_low%0d", i), 32'(s_err), 32'd0);
            chk($sformatf("to_freeze%0d", i),  32'(s_frz), 32'd1);
            @(negedge clk_i);
        end
        chk("to_err_set",    32'(s_err), 32'd1);
        chk("to_state_err",  32'(s_dbg), 32'd2);
        chk("to_scnt_sat",   32'(s_scnt), 32'd7);
        dstall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("err_freeze%0d", i), 32'(s_frz), 32'd1);
            chk($sformatf("err_pcw%0d", i),    32'(s_pcw), 32'd0);
            chk($sformatf("err_sticky%0d", i), 32'(s_err), 32'd1);
            @(negedge clk_i);
        end
        chk("err_scnt_sat", 32'(s_scnt), 32'd7);
        #2 rst_i = 1'b0;
        #1;
        chk("err_rst_error",  32'(s_err), 32'd0);
        chk("err_rst_freeze", 32'(s_frz), 32'd0);
        chk("err_rst_state",  32'(s_dbg), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Back-to-back load-use, saturation of the small LU counter
        do_reset();
        set_lu_hazard();
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("b2b_bubble%0d", i), 32'(bub), 32'd1);
            @(negedge clk_i);
        end
        idle();
        #1;
        chk("b2b_lcnt",     lcnt, 32'd9);
        chk("b2b_lcnt_sat", 32'(s_lcnt), 32'd7);

        // Asynchronous reset in cycle 3 of a miss
        do_reset();
        dstall = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("ar_pre_scnt",  scnt, 32'd3);
        chk("ar_pre_state", 32'(dbg), 32'd1);
        #2;
        rst_i = 1'b0;
        dstall = 1'b0;
        #1;
        chk("ar_freeze", 32'(frz), 32'd0);
        chk("ar_pcw",    32'(pcw), 32'd1);
        chk("ar_scnt",   scnt, 32'd0);
        chk("ar_state",  32'(dbg), 32'd0);
        chk("ar_error",  32'(err), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Randomized run against the reference model
        do_reset();
        m_run = 0; m_err = 1'b0; m_scnt = 0; m_lcnt = 0;
        for (int c = 0; c < 400; c++) begin
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            uses2   = 1'($urandom_range(0, 1));
            memread = 1'($urandom_range(0, 1));
            dstall  = ($urandom_range(0, 9) < 3);
            #1;
            m_lu  = memread && (rd != 0) && ((rd == rs1) || (uses2 && (rd == rs2)));
            m_frz = m_err || dstall;
            chk("rnd_freeze", 32'(frz), 32'(m_frz));
            chk("rnd_bubble", 32'(bub), 32'(m_lu && !m_frz));
            chk("rnd_ifid",   32'(ifid), 32'(m_frz || m_lu));
            chk("rnd_pcw",    32'(pcw), 32'(!(m_frz || m_lu)));
            chk("rnd_error",  32'(err), 32'(m_err));
            chk("rnd_scnt",   scnt, 32'(m_scnt));
            chk("rnd_lcnt",   lcnt, 32'(m_lcnt));
            if (m_frz) m_scnt++;
            if (m_lu && !m_frz) m_lcnt++;
            if (!m_err) begin
                if (dstall) begin
                    m_run++;
                    if (m_run == 1024) m_err = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
            @(negedge clk_i);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
